// File: rtl/pwm_leg_deadtime.sv
// pwm_leg_deadtime
//   One PWM leg of the phase-shifted modulator. The incoming triangular
//   carrier is compared against the active duty reference, and the result
//   drives a complementary high/low gate pair with a programmable dead-time.
//   Duty and dead-time are double-buffered. A write lands in a shadow, and the
//   shadow is copied to the active registers only at a carrier extreme, so a
//   reference change never splits a carrier half-period.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   carrier   triangular carrier sample, 0 .. 2^WIDTH-1
//   en        leg enable; low forces both gates off
//   duty_wr   one-cycle write strobe for duty_in / dead_in
//   duty_in   new duty reference
//   dead_in   new dead-time in clk cycles
//   pwm_q     registered raw comparison, carrier < active duty
//   gate_hi   high-side gate
//   gate_lo   low-side gate
//   pending   shadow holds a write not yet applied
//   upd_done  one-cycle pulse when the active registers are reloaded
module pwm_leg_deadtime #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned DEAD_W   = 4,
  parameter int unsigned DEAD_RST = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  carrier,
  input  logic              en,
  input  logic              duty_wr,
  input  logic [WIDTH-1:0]  duty_in,
  input  logic [DEAD_W-1:0] dead_in,
  output logic              pwm_q,
  output logic              gate_hi,
  output logic              gate_lo,
  output logic              pending,
  output logic              upd_done
);

  localparam logic [DEAD_W-1:0] DEAD_RST_V = DEAD_W'(DEAD_RST);
  localparam logic [DEAD_W-1:0] DCNT_ONE   = DEAD_W'(1);

  typedef enum logic [2:0] {
    S_OFF = 3'd0,
    S_LO  = 3'd1,
    S_DTH = 3'd2,
    S_HI  = 3'd3,
    S_DTL = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DEAD_W-1:0] dcnt_q, dcnt_d;
  logic [WIDTH-1:0]  duty_act_q, duty_sh_q;
  logic [DEAD_W-1:0] dead_act_q, dead_sh_q;
  logic              pending_q, upd_done_q;
  logic              extreme;
  logic              dead_zero;

  assign extreme   = (carrier == '0) || (carrier == {WIDTH{1'b1}});
  assign dead_zero = (dead_act_q == '0);

  // Stage: reference buffering and carrier comparison
  // A write that coincides with an extreme skips the shadow entirely, so the
  // newest value is never held back for a whole carrier half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q      <= 1'b0;
      duty_act_q <= '0;
      dead_act_q <= DEAD_RST_V;
      duty_sh_q  <= '0;
      dead_sh_q  <= '0;
      pending_q  <= 1'b0;
      upd_done_q <= 1'b0;
    end else begin
      pwm_q <= (carrier < duty_act_q);
      if (duty_wr && extreme) begin
        duty_act_q <= duty_in;
        dead_act_q <= dead_in;
        pending_q  <= 1'b0;
        upd_done_q <= 1'b1;
      end else if (duty_wr) begin
        duty_sh_q  <= duty_in;
        dead_sh_q  <= dead_in;
        pending_q  <= 1'b1;
        upd_done_q <= 1'b0;
      end else if (extreme && pending_q) begin
        duty_act_q <= duty_sh_q;
        dead_act_q <= dead_sh_q;
        pending_q  <= 1'b0;
        upd_done_q <= 1'b1;
      end else begin
        upd_done_q <= 1'b0;
      end
    end
  end

  // Stage: gate sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // The dead counter is loaded from dead_act only on entry to a dead-time
  // state, so a reference update never stretches or cuts a running interval.
  // In a dead-time state the comparator reverting aborts straight back to
  // the gate that was just released.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    if (!en) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF: begin
          if (dead_zero) begin
            state_d = S_LO;
          end else begin
            state_d = S_DTL;
            dcnt_d  = dead_act_q;
          end
        end
        S_LO: begin
          if (pwm_q) begin
            if (dead_zero) begin
              state_d = S_HI;
            end else begin
              state_d = S_DTH;
              dcnt_d  = dead_act_q;
            end
          end
        end
        S_HI: begin
          if (!pwm_q) begin
            if (dead_zero) begin
              state_d = S_LO;
            end else begin
              state_d = S_DTL;
              dcnt_d  = dead_act_q;
            end
          end
        end
        S_DTH: begin
          if (!pwm_q) begin
            state_d = S_LO;
          end else if (dcnt_q == DCNT_ONE) begin
            state_d = S_HI;
          end else begin
            dcnt_d = dcnt_q - DCNT_ONE;
          end
        end
        S_DTL: begin
          if (pwm_q) begin
            state_d = S_HI;
          end else if (dcnt_q == DCNT_ONE) begin
            state_d = S_LO;
          end else begin
            dcnt_d = dcnt_q - DCNT_ONE;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // Gates decode from the state register alone, so they cannot glitch on
  // input changes and can never be on together.
  assign gate_hi  = (state_q == S_HI);
  assign gate_lo  = (state_q == S_LO);
  assign pending  = pending_q;
  assign upd_done = upd_done_q;

endmodule

// File: tb/tb_pwm_leg_deadtime.sv
module tb_pwm_leg_deadtime;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] carrier;
  logic       en;
  logic       duty_wr;
  logic [5:0] duty_in;
  logic [3:0] dead_in;
  logic       pwm_q, gate_hi, gate_lo, pending, upd_done;

  always #5 clk = ~clk;

  pwm_leg_deadtime #(.WIDTH(6), .DEAD_W(4), .DEAD_RST(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .carrier  (carrier),
    .en       (en),
    .duty_wr  (duty_wr),
    .duty_in  (duty_in),
    .dead_in  (dead_in),
    .pwm_q    (pwm_q),
    .gate_hi  (gate_hi),
    .gate_lo  (gate_lo),
    .pending  (pending),
    .upd_done (upd_done)
  );

  int n_vec = 0;
  int n_err = 0;
  bit up;
  logic [5:0] car_at_edge;

  // Reference model: the leg is described by which gate it is heading for
  // (m_side: -1 none, 0 low, 1 high) and how many dead cycles remain (m_gap).
  int         m_side, m_gap;
  logic       m_pwm, m_pend, m_upd;
  logic [5:0] m_duty_act, m_duty_sh;
  logic [3:0] m_dead_act, m_dead_sh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_side = -1; m_gap = 0; m_pwm = 1'b0; m_pend = 1'b0; m_upd = 1'b0;
    m_duty_act = 6'd0; m_duty_sh = 6'd0; m_dead_act = 4'd2; m_dead_sh = 4'd0;
  endtask

  task automatic model_edge();
    int  want;
    bit  ext;
    if (!en) begin
      m_side = -1; m_gap = 0;
    end else if (m_side == -1) begin
      m_side = 0; m_gap = int'(m_dead_act);
    end else begin
      want = m_pwm ? 1 : 0;
      if (want != m_side) begin
        m_gap  = (m_gap > 0) ? 0 : int'(m_dead_act);
        m_side = want;
      end else if (m_gap > 0) begin
        m_gap--;
      end
    end
    m_pwm = (carrier < m_duty_act);
    ext = (carrier == 6'd0) || (carrier == 6'd63);
    if (duty_wr && ext) begin
      m_duty_act = duty_in; m_dead_act = dead_in; m_pend = 1'b0; m_upd = 1'b1;
    end else if (duty_wr) begin
      m_duty_sh = duty_in; m_dead_sh = dead_in; m_pend = 1'b1; m_upd = 1'b0;
    end else if (ext && m_pend) begin
      m_duty_act = m_duty_sh; m_dead_act = m_dead_sh; m_pend = 1'b0; m_upd = 1'b1;
    end else begin
      m_upd = 1'b0;
    end
  endtask

  function automatic void advance_carrier();
    if (up) begin
      if (carrier == 6'd63) begin up = 1'b0; carrier = 6'd62; end
      else carrier = carrier + 6'd1;
    end else begin
      if (carrier == 6'd0) begin up = 1'b1; carrier = 6'd1; end
      else carrier = carrier - 6'd1;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    car_at_edge = carrier;
    model_edge();
    #1;
    chk("pwm_q",    32'(pwm_q),    32'(m_pwm));
    chk("gate_hi",  32'(gate_hi),  32'(m_side == 1 && m_gap == 0));
    chk("gate_lo",  32'(gate_lo),  32'(m_side == 0 && m_gap == 0));
    chk("pending",  32'(pending),  32'(m_pend));
    chk("upd_done", 32'(upd_done), 32'(m_upd));
    chk("no_overlap", 32'(gate_hi & gate_lo), 32'd0);
    duty_wr = 1'b0;
    advance_carrier();
  endtask

  task automatic write_ref(input logic [5:0] d, input logic [3:0] t);
    duty_in = d; dead_in = t; duty_wr = 1'b1;
    step();
  endtask

  task automatic wait_upd(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (upd_done) begin seen = 1'b1; break; end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One carrier period of observation: counts of pwm high, gate_hi high,
  // gate_lo high, and cycles where both gates are equal.
  task automatic measure(output int cp, output int ch, output int cl, output int ceq);
    cp = 0; ch = 0; cl = 0; ceq = 0;
    for (int i = 0; i < 126; i++) begin
      step();
      if (pwm_q)   cp++;
      if (gate_hi) ch++;
      if (gate_lo) cl++;
      if (gate_hi === gate_lo) ceq++;
    end
  endtask

  initial begin
    int  cp, ch, cl, ceq, nupd, lim;
    bit  found, prev_lo;

    rst = 1'b1; carrier = 6'd0; up = 1'b1; en = 1'b0; duty_wr = 1'b0;
    duty_in = 6'd0; dead_in = 4'd0; car_at_edge = 6'd0;
    model_reset();
    #12;
    chk("rst_pwm",  32'(pwm_q),    32'd0);
    chk("rst_hi",   32'(gate_hi),  32'd0);
    chk("rst_lo",   32'(gate_lo),  32'd0);
    chk("rst_pend", 32'(pending),  32'd0);
    chk("rst_upd",  32'(upd_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Enable with reset duty 0 and reset dead-time 2
    en = 1'b1;
    step(); chk("en_dt1_lo", 32'(gate_lo), 32'd0);
    step(); chk("en_dt2_lo", 32'(gate_lo), 32'd0);
    step(); chk("en_lo_on",  32'(gate_lo), 32'd1);
    measure(cp, ch, cl, ceq);
    chk("d0_pwm_cnt", cp, 0);
    chk("d0_hi_cnt",  ch, 0);
    chk("d0_lo_cnt",  cl, 126);

    // Duty 32, dead 3
    lim = 0;
    while (carrier != 6'd10 && lim < 200) begin step(); lim++; end
    write_ref(6'd32, 4'd3);
    chk("d32_pending", 32'(pending), 32'd1);
    wait_upd("d32_upd_seen");
    chk("d32_upd_at_peak", 32'(car_at_edge), 32'd63);
    run(126);
    measure(cp, ch, cl, ceq);
    chk("d32_pwm_cnt", cp, 63);
    chk("d32_hi_cnt",  ch, 60);
    chk("d32_lo_cnt",  cl, 60);
    chk("d32_gap_cnt", ceq, 6);

    // Duty 2, dead 4: short pulse aborts the dead-time
    write_ref(6'd2, 4'd4);
    wait_upd("d2_upd_seen");
    run(126);
    measure(cp, ch, cl, ceq);
    chk("d2_pwm_cnt", cp, 3);
    chk("d2_hi_cnt",  ch, 0);
    chk("d2_lo_cnt",  cl, 123);

    // Two writes before the peak: only the second takes effect
    lim = 0;
    while (!(carrier == 6'd40 && up) && lim < 200) begin step(); lim++; end
    nupd = 0;
    write_ref(6'd20, 4'd1);
    if (upd_done) nupd++;
    chk("dbl_pend1", 32'(pending), 32'd1);
    while (carrier != 6'd50) begin step(); if (upd_done) nupd++; end
    write_ref(6'd45, 4'd2);
    if (upd_done) nupd++;
    lim = 0;
    while (car_at_edge != 6'd63 && lim < 40) begin
      step();
      if (upd_done) nupd++;
      if (car_at_edge != 6'd63) chk("dbl_pend_hold", 32'(pending), 32'd1);
      lim++;
    end
    chk("dbl_pend_clr", 32'(pending), 32'd0);
    lim = 0;
    while (car_at_edge != 6'd44 && lim < 40) begin step(); if (upd_done) nupd++; lim++; end
    chk("dbl_one_upd", nupd, 1);
    chk("dbl_second_applied", 32'(pwm_q), 32'd1);

    // Write coincident with carrier 0 bypasses the shadow
    lim = 0;
    while (carrier != 6'd0 && lim < 200) begin step(); lim++; end
    write_ref(6'd20, 4'd0);
    chk("bypass_pend", 32'(pending),  32'd0);
    chk("bypass_upd",  32'(upd_done), 32'd1);
    run(126);
    measure(cp, ch, cl, ceq);
    chk("dz_pwm_cnt", cp, 39);
    chk("dz_hi_cnt",  ch, 39);
    chk("dz_lo_cnt",  cl, 87);
    chk("dz_complement", ceq, 0);

    // Drop enable while the high side is on
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (gate_hi) begin found = 1'b1; break; end
      step();
    end
    chk("en_drop_found_hi", 32'(found), 32'd1);
    en = 1'b0;
    step();
    chk("en_drop_hi", 32'(gate_hi), 32'd0);
    chk("en_drop_lo", 32'(gate_lo), 32'd0);
    en = 1'b1;

    // Asynchronous reset in the middle of a high-side dead-time
    write_ref(6'd32, 4'd8);
    wait_upd("dth_upd_seen");
    found = 1'b0;
    prev_lo = gate_lo;
    for (int i = 0; i < 300; i++) begin
      step();
      if (prev_lo && !gate_lo && !gate_hi) begin found = 1'b1; break; end
      prev_lo = gate_lo;
    end
    chk("dth_found", 32'(found), 32'd1);
    step();
    chk("dth_still_off_hi", 32'(gate_hi), 32'd0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_hi",   32'(gate_hi),  32'd0);
    chk("arst_lo",   32'(gate_lo),  32'd0);
    chk("arst_pwm",  32'(pwm_q),    32'd0);
    chk("arst_pend", 32'(pending),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    measure(cp, ch, cl, ceq);
    chk("arst_duty0_pwm", cp, 0);
    chk("arst_duty0_hi",  ch, 0);

    // Randomized writes and enable toggles against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        duty_in = 6'($urandom_range(0, 63));
        dead_in = 4'($urandom_range(0, 15));
        duty_wr = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) en = ~en;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
